alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Sequencing and capture stage wrapped around the 4-bit combinational ALU. It accepts operation commands over a valid/ready handshake and drives registered operands and the select code into the ALU. It then captures the ALU's 5-bit result, normalises the carry bit, and presents the result downstream over a second valid/ready handshake. It also holds a 4-bit accumulator for chained operations and a saturating carry-event counter.

## Interface
- CNT_W, 8, width of carry-event counter
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  0=add, 1=and, 2=or, 3=nand
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- cmd_acc  in  1  1: use accumulator instead of cmd_a as operand A
- alu_a  out  4  registered operand A to the ALU
- alu_b  out  4  registered operand B to the ALU
- alu_s  out  2  registered select to the ALU (equals cmd_op)
- alu_out  in  5  ALU result
- res_valid  out  1  result present
- res_ready  in  1  downstream accepts result
- res_data  out  5  captured result
- res_carry  out  1  carry of captured add
- cnt_clr  in  1  synchronous clear of carry_cnt
- carry_cnt  out  CNT_W  number of captured adds with carry, saturating

## Operation
- FSM states: IDLE, DRIVE, HOLD.
- **IDLE**
  - cmd_ready=1, combinationally decoded from state.
  - On cmd_valid&&cmd_ready: load alu_a (acc if cmd_acc else cmd_a), alu_b=cmd_b, alu_s=cmd_op, then go to DRIVE.
- **DRIVE**
  - One cycle for ALU settling; cmd_ready=0.
  - At the end of DRIVE, capture the result, set res_valid=1, and go to HOLD.
- **HOLD**
  - res_valid=1 and res_data/res_carry are held stable.
  - On res_ready go to IDLE and clear res_valid.
  - cmd_valid is ignored.
- **Capture rules**
  - op 0 (add): res_data=alu_out, res_carry=alu_out[4].
  - ops 1–3: res_data={1'b0, alu_out[3:0]}, res_carry=0. ALU bit 4 is ignored because it is meaningless for logic ops; nand sets it.
  - acc <= alu_out[3:0] on every capture.
- **Counter**
  - carry_cnt increments on a capture with res_carry=1 and saturates at 2^CNT_W-1.
  - If cnt_clr coincides with an increment, the clear wins and the result is 0.
- alu_a, alu_b and alu_s hold their values until the next accepted command.

## Timing
- Reset (async assert):
  - state=IDLE, so cmd_ready=1.
  - alu_a=0, alu_b=0, alu_s=0, acc=0.
  - res_valid=0, res_data=0, res_carry=0, carry_cnt=0.
- Command accepted at edge N:
  - alu_* are valid after edge N.
  - res_valid rises after edge N+1, giving 2-cycle latency.
- With res_ready held at 1, res_valid is high for exactly one cycle and cmd_ready returns after edge N+2.
- Minimum command spacing is 3 cycles.
- Backpressure: HOLD persists indefinitely with outputs stable; no command is lost because cmd_ready=0 throughout.
- Reset mid-operation (DRIVE or HOLD): immediate abort, res_valid drops asynchronously, no counter or accumulator update.
- cmd_acc=1 uses the accumulator value captured by the most recent completed operation. After reset the accumulator is 0.

## Test plan
- **Add with carry:** add 9+8 → res_valid 2 cycles after accept, res_data=0x11, res_carry=1, carry_cnt=1.
- **Logic ops:**
  - nand 0xF,0xF → res_data=0x00, res_carry=0, counter unchanged.
  - or 0xA,0x5 → res_data=0x0F.
- **Accumulator chain:** add 3+4 (res 0x07), then cmd_acc=1, op and, b=0x5 → alu_a=7, res_data=0x05, acc=5.
- **Backpressure:**
  - Hold res_ready=0 for 5 cycles while cmd_valid=1 with a new command → res_data stable, cmd_ready=0 throughout, second command accepted only after the first result handshake.
- **Counter saturation and clear:**
  - With CNT_W=2, perform four adds 0xF+0x1 → carry_cnt=3.
  - Assert cnt_clr in the same cycle as a fifth carry capture → carry_cnt=0.
- **Reset mid-operation:** assert rst during DRIVE → res_valid=0 immediately, carry_cnt and acc unchanged from reset (0), cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command sequencer and result capture stage for a 4-bit combinational ALU.
// Registers operands and select, captures the ALU result, and tracks an accumulator and carry count.
module alu_op_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic             cmd_acc,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_s,
    input  logic [4:0]       alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [4:0]       res_data,
    output logic             res_carry,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] carry_cnt
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StHold  = 2'd2
    } state_e;

    localparam logic [1:0]       OpAdd  = 2'd0;
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           r_state;
    state_e           w_state_next;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [1:0]       r_alu_s;
    logic [3:0]       r_acc;
    logic [4:0]       r_res_data;
    logic             r_res_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic       w_accept;
    logic       w_capture;
    logic [4:0] w_cap_data;
    logic       w_cap_carry;

    assign w_accept  = cmd_valid && (r_state == StIdle);
    assign w_capture = (r_state == StDrive);

    // Bit 4 only carries meaning for add; logic ops (nand in particular) may set it.
    assign w_cap_carry = (r_alu_s == OpAdd) && alu_out[4];
    assign w_cap_data  = (r_alu_s == OpAdd) ? alu_out : {1'b0, alu_out[3:0]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    w_state_next = StDrive;
                end
            end
            StDrive: begin
                w_state_next = StHold;
            end
            StHold: begin
                if (res_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a <= 4'd0;
            r_alu_b <= 4'd0;
            r_alu_s <= 2'd0;
        end else if (w_accept) begin
            r_alu_a <= cmd_acc ? r_acc : cmd_a;
            r_alu_b <= cmd_b;
            r_alu_s <= cmd_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= 4'd0;
            r_res_data  <= 5'd0;
            r_res_carry <= 1'b0;
        end else if (w_capture) begin
            r_acc       <= alu_out[3:0];
            r_res_data  <= w_cap_data;
            r_res_carry <= w_cap_carry;
        end
    end

    // Clear has priority over a coincident increment.
    always_comb begin
        w_cnt_next = r_cnt;
        if (cnt_clr) begin
            w_cnt_next = '0;
        end else if (w_capture && w_cap_carry && (r_cnt != CntMax)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign cmd_ready = (r_state == StIdle);
    assign res_valid = (r_state == StHold);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign res_data  = r_res_data;
    assign res_carry = r_res_carry;
    assign carry_cnt = r_cnt;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_op_sequencer;

    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic             cmd_acc;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [1:0]       alu_s;
    logic [4:0]       alu_out;
    logic             res_valid;
    logic             res_ready;
    logic [4:0]       res_data;
    logic             res_carry;
    logic             cnt_clr;
    logic [CNT_W-1:0] carry_cnt;

    int checks;
    int errors;

    alu_op_sequencer #(
        .CNT_W(CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_acc  (cmd_acc),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_out  (alu_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_carry(res_carry),
        .cnt_clr  (cnt_clr),
        .carry_cnt(carry_cnt)
    );

    // Reference ALU; nand drives bit 4 high so the sequencer must mask it.
    always_comb begin
        alu_out = 5'd0;
        case (alu_s)
            2'd0: alu_out = {1'b0, alu_a} + {1'b0, alu_b};
            2'd1: alu_out = {1'b0, alu_a & alu_b};
            2'd2: alu_out = {1'b0, alu_a | alu_b};
            default: alu_out = {1'b1, ~(alu_a & alu_b)};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with res_ready given in the HOLD cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic acc, input logic clr,
                          input logic [3:0] exp_a, input logic [4:0] exp_data,
                          input logic exp_carry, input logic [CNT_W-1:0] exp_cnt);
        chk({tag, " cmd_ready pre"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_acc   = acc;
        step();
        cmd_valid = 1'b0;
        chk({tag, " alu_a"}, 32'(alu_a), 32'(exp_a));
        chk({tag, " alu_b"}, 32'(alu_b), 32'(b));
        chk({tag, " alu_s"}, 32'(alu_s), 32'(op));
        chk({tag, " drive cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, " drive res_valid"}, 32'(res_valid), 32'd0);
        cnt_clr = clr;
        step();
        cnt_clr = 1'b0;
        chk({tag, " res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, " res_data"}, 32'(res_data), 32'(exp_data));
        chk({tag, " res_carry"}, 32'(res_carry), 32'(exp_carry));
        chk({tag, " carry_cnt"}, 32'(carry_cnt), 32'(exp_cnt));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, " post res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, " post cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [3:0]       a;
        logic [3:0]       b;
        logic             acc;
        logic [3:0]       exp_a;
        logic [4:0]       exp_data;
        logic             exp_carry;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_a     = 4'd0;
        cmd_b     = 4'd0;
        cmd_acc   = 1'b0;
        res_ready = 1'b0;
        cnt_clr   = 1'b0;

        //          op    a      b      acc   exp_a  data    c     cnt
        vecs[0] = '{2'd0, 4'h9, 4'h8, 1'b0, 4'h9, 5'h11, 1'b1, 2'd1};  // add carry
        vecs[1] = '{2'd3, 4'hF, 4'hF, 1'b0, 4'hF, 5'h00, 1'b0, 2'd1};  // nand, bit4 masked
        vecs[2] = '{2'd2, 4'hA, 4'h5, 1'b0, 4'hA, 5'h0F, 1'b0, 2'd1};  // or
        vecs[3] = '{2'd0, 4'h3, 4'h4, 1'b0, 4'h3, 5'h07, 1'b0, 2'd1};  // add, acc=7
        vecs[4] = '{2'd1, 4'h0, 4'h5, 1'b1, 4'h7, 5'h05, 1'b0, 2'd1};  // and with acc
        vecs[5] = '{2'd0, 4'h0, 4'hB, 1'b1, 4'h5, 5'h10, 1'b1, 2'd2};  // acc 5 + B
        vecs[6] = '{2'd0, 4'hF, 4'h1, 1'b0, 4'hF, 5'h10, 1'b1, 2'd3};
        vecs[7] = '{2'd0, 4'hF, 4'h1, 1'b0, 4'hF, 5'h10, 1'b1, 2'd3};  // saturated

        repeat (2) @(posedge clk);
        #1;
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset res_valid", 32'(res_valid), 32'd0);
        chk("reset alu_a", 32'(alu_a), 32'd0);
        chk("reset alu_b", 32'(alu_b), 32'd0);
        chk("reset alu_s", 32'(alu_s), 32'd0);
        chk("reset res_data", 32'(res_data), 32'd0);
        chk("reset res_carry", 32'(res_carry), 32'd0);
        chk("reset carry_cnt", 32'(carry_cnt), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].acc,
                   1'b0, vecs[i].exp_a, vecs[i].exp_data, vecs[i].exp_carry, vecs[i].exp_cnt);
        end

        // Clear coincides with a carry capture at saturation.
        run_op("clr_vs_inc", 2'd0, 4'hF, 4'h1, 1'b0, 1'b1, 4'hF, 5'h10, 1'b1, 2'd0);

        // Backpressure: new command pending while the result is held.
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_a     = 4'h2;
        cmd_b     = 4'h3;
        cmd_acc   = 1'b0;
        step();
        cmd_op = 2'd2;
        cmd_a  = 4'h1;
        cmd_b  = 4'h2;
        step();
        chk("bp res_valid", 32'(res_valid), 32'd1);
        chk("bp res_data", 32'(res_data), 32'h05);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp hold%0d res_valid", i), 32'(res_valid), 32'd1);
            chk($sformatf("bp hold%0d cmd_ready", i), 32'(cmd_ready), 32'd0);
            chk($sformatf("bp hold%0d res_data", i), 32'(res_data), 32'h05);
            chk($sformatf("bp hold%0d alu_a", i), 32'(alu_a), 32'h2);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("bp release res_valid", 32'(res_valid), 32'd0);
        chk("bp release cmd_ready", 32'(cmd_ready), 32'd1);
        chk("bp release alu_a", 32'(alu_a), 32'h2);
        step();
        cmd_valid = 1'b0;
        chk("bp second alu_a", 32'(alu_a), 32'h1);
        chk("bp second alu_b", 32'(alu_b), 32'h2);
        chk("bp second alu_s", 32'(alu_s), 32'd2);
        chk("bp second cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("bp second res_data", 32'(res_data), 32'h03);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Reset during DRIVE.
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_a     = 4'hF;
        cmd_b     = 4'h1;
        step();
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst drive res_valid", 32'(res_valid), 32'd0);
        chk("rst drive cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst drive alu_a", 32'(alu_a), 32'd0);
        step();
        rst = 1'b0;
        chk("rst drive carry_cnt", 32'(carry_cnt), 32'd0);
        chk("rst drive res_data", 32'(res_data), 32'd0);
        step();
        chk("rst drive idle cmd_ready", 32'(cmd_ready), 32'd1);

        // Reset during HOLD drops res_valid without a clock edge.
        run_op("pre_hold", 2'd0, 4'hF, 4'h1, 1'b0, 1'b0, 4'hF, 5'h10, 1'b1, 2'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_a     = 4'hE;
        cmd_b     = 4'h3;
        step();
        cmd_valid = 1'b0;
        step();
        chk("hold res_valid", 32'(res_valid), 32'd1);
        chk("hold carry_cnt", 32'(carry_cnt), 32'd2);
        rst = 1'b1;
        #1;
        chk("rst hold res_valid", 32'(res_valid), 32'd0);
        chk("rst hold res_data", 32'(res_data), 32'd0);
        chk("rst hold carry_cnt", 32'(carry_cnt), 32'd0);
        chk("rst hold cmd_ready", 32'(cmd_ready), 32'd1);
        #2;
        rst = 1'b0;
        step();

        // Accumulator is zero again after reset.
        run_op("acc_after_rst", 2'd2, 4'h9, 4'h0, 1'b1, 1'b0, 4'h0, 5'h00, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
